// File: rtl/popcount_sched.sv
// Round-robin job sequencer sharing one popcount datapath among NREQ requesters.
// Optional drain timeout and sticky REQ_ERR: define POPCOUNT_SCHED_TIMEOUT_EN.
module popcount_sched #(
  parameter int NREQ    = 2,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 256
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [NREQ-1:0]       REQ_START,
  input  logic [NREQ*LEN_W-1:0] REQ_LEN,
  input  logic [NREQ*32-1:0]    REQ_DATA,
  input  logic [NREQ-1:0]       REQ_DATA_VALID,
  output logic [NREQ-1:0]       REQ_DATA_READY,
  output logic [NREQ-1:0]       REQ_DONE,
  output logic [NREQ*32-1:0]    REQ_RESULT,
  output logic [NREQ-1:0]       REQ_ERR,
  output logic [31:0]           PC_WRITE_DATA,
  output logic                  PC_WRITE_VALID,
  input  logic [31:0]           PC_COUNT,
  output logic                  PC_COUNT_RST,
  input  logic                  PC_COUNT_BUSY
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || LEN_W < 1 || TIMEOUT < 1) begin : g_bad_cfg
    $error("popcount_sched: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_CAPTURE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [NREQ-1:0]  r_pend;
  logic [GW-1:0]    r_gnt;
  logic [GW-1:0]    r_rr;
  logic [GW-1:0]    w_arb_idx;
  logic             w_arb_hit;
  logic             w_grant;
  logic [NREQ-1:0]  w_start_ok;
  logic [LEN_W-1:0] r_len [NREQ];
  logic [LEN_W-1:0] r_rem;
  logic [31:0]      r_result [NREQ];
  logic [31:0]      w_sel_data;
  logic             w_sel_valid;
  logic             w_accept;
  logic             w_drain_exit;

  function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] base, input int step);
    int s;
    s = (int'(base) + step) % NREQ;
    return GW'(s);
  endfunction

  // Round-robin search starting one past the last served requester.
  always_comb begin
    w_arb_hit = 1'b0;
    w_arb_idx = r_rr;
    for (int i = 1; i <= NREQ; i++) begin
      if (!w_arb_hit && r_pend[wrap_inc(r_rr, i)]) begin
        w_arb_hit = 1'b1;
        w_arb_idx = wrap_inc(r_rr, i);
      end
    end
  end

  assign w_grant = (r_state == S_IDLE) && w_arb_hit;

  always_comb begin
    w_sel_data  = '0;
    w_sel_valid = 1'b0;
    w_start_ok  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_gnt == GW'(i)) begin
        w_sel_data  = REQ_DATA[i*32 +: 32];
        w_sel_valid = REQ_DATA_VALID[i];
      end
      w_start_ok[i] = REQ_START[i] && !((r_state != S_IDLE) && (r_gnt == GW'(i)));
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE:    if (w_arb_hit) w_state_nxt = S_CLEAR;
      S_CLEAR:   w_state_nxt = (r_rem != '0) ? S_STREAM : S_DRAIN;
      S_STREAM: begin
        w_accept = w_sel_valid;
        if (w_sel_valid && (r_rem == LEN_W'(1))) w_state_nxt = S_DRAIN;
      end
      S_DRAIN:   if (w_drain_exit) w_state_nxt = S_CAPTURE;
      S_CAPTURE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= S_IDLE;
      r_pend  <= '0;
      r_gnt   <= '0;
      r_rr    <= GW'(NREQ - 1);
    end else begin
      r_state <= w_state_nxt;
      for (int i = 0; i < NREQ; i++) begin
        if (w_grant && (w_arb_idx == GW'(i))) r_pend[i] <= 1'b0;
        if (w_start_ok[i]) r_pend[i] <= 1'b1;
      end
      if (w_grant) r_gnt <= w_arb_idx;
      if (r_state == S_CAPTURE) r_rr <= r_gnt;
    end
  end

  always_ff @(posedge ACLK) begin
    for (int i = 0; i < NREQ; i++) begin
      if (w_start_ok[i]) r_len[i] <= REQ_LEN[i*LEN_W +: LEN_W];
    end
    if (w_grant) r_rem <= r_len[w_arb_idx];
    else if (w_accept) r_rem <= r_rem - LEN_W'(1);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < NREQ; i++) r_result[i] <= '0;
    end else if (r_state == S_CAPTURE) begin
      r_result[r_gnt] <= PC_COUNT;
    end
  end

`ifdef POPCOUNT_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0]   r_tmo_cnt;
  logic            r_tmo_hit;
  logic [NREQ-1:0] r_err;
  logic            w_tmo;

  // Only busy cycles in DRAIN count toward the limit.
  assign w_tmo        = PC_COUNT_BUSY && (r_tmo_cnt == TW'(TIMEOUT - 1));
  assign w_drain_exit = !PC_COUNT_BUSY || w_tmo;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_tmo_cnt <= '0;
      r_tmo_hit <= 1'b0;
      r_err     <= '0;
    end else begin
      if (r_state != S_DRAIN) r_tmo_cnt <= '0;
      else if (PC_COUNT_BUSY) r_tmo_cnt <= r_tmo_cnt + TW'(1);
      r_tmo_hit <= (r_state == S_DRAIN) && w_tmo;
      for (int i = 0; i < NREQ; i++) begin
        if (REQ_START[i]) r_err[i] <= 1'b0;
      end
      if ((r_state == S_CAPTURE) && r_tmo_hit) r_err[r_gnt] <= 1'b1;
    end
  end

  assign REQ_ERR = r_err;
`else
  assign w_drain_exit = !PC_COUNT_BUSY;
  assign REQ_ERR      = '0;
`endif

  assign PC_WRITE_VALID = w_accept;
  assign PC_WRITE_DATA  = w_accept ? w_sel_data : 32'd0;
  assign PC_COUNT_RST   = (r_state == S_CLEAR);

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign REQ_DATA_READY[gi]       = (r_state == S_STREAM)  && (r_gnt == GW'(gi));
    assign REQ_DONE[gi]             = (r_state == S_CAPTURE) && (r_gnt == GW'(gi));
    assign REQ_RESULT[gi*32 +: 32]  = r_result[gi];
  end

endmodule

// File: tb/tb_popcount_sched.sv
// Directed bench for popcount_sched with a behavioural popcount unit (3-cycle busy tail).
module tb_popcount_sched;
  localparam int NREQ  = 2;
  localparam int LEN_W = 16;

  logic                  aclk = 1'b0;
  logic                  areset = 1'b1;
  logic [NREQ-1:0]       req_start = '0;
  logic [NREQ*LEN_W-1:0] req_len = '0;
  logic [NREQ*32-1:0]    req_data = '0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_done;
  logic [NREQ*32-1:0]    req_result;
  logic [NREQ-1:0]       req_err;
  logic [31:0]           pc_wdata;
  logic                  pc_wvalid;
  logic [31:0]           pc_count = '0;
  logic                  pc_rst;
  logic                  pc_busy;
  logic                  force_busy = 1'b0;
  int                    busy_cnt = 0;

  popcount_sched #(.NREQ(NREQ), .LEN_W(LEN_W), .TIMEOUT(8)) dut (
    .ACLK(aclk), .ARESET(areset),
    .REQ_START(req_start), .REQ_LEN(req_len), .REQ_DATA(req_data),
    .REQ_DATA_VALID(req_valid), .REQ_DATA_READY(req_ready), .REQ_DONE(req_done),
    .REQ_RESULT(req_result), .REQ_ERR(req_err),
    .PC_WRITE_DATA(pc_wdata), .PC_WRITE_VALID(pc_wvalid), .PC_COUNT(pc_count),
    .PC_COUNT_RST(pc_rst), .PC_COUNT_BUSY(pc_busy)
  );

  always #5 aclk = ~aclk;

  // Popcount unit model: running total, busy for 3 cycles after each write.
  always @(posedge aclk) begin
    if (pc_rst) pc_count <= '0;
    else if (pc_wvalid) pc_count <= pc_count + 32'($countones(pc_wdata));
    if (pc_wvalid) busy_cnt <= 3;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign pc_busy = force_busy || (busy_cnt != 0);

  int cyc = 0, wr_cnt = 0, rst_cnt = 0, last_wr = 0, rst_cyc = 0;
  int done_cnt [NREQ] = '{default: 0};
  int rdy_cnt  [NREQ] = '{default: 0};
  int done_q [$];

  always @(posedge aclk) begin
    cyc++;
    if (pc_wvalid) begin wr_cnt++; last_wr = cyc; end
    if (pc_rst) begin rst_cnt++; rst_cyc = cyc; end
    for (int r = 0; r < NREQ; r++) begin
      if (req_done[r]) begin done_cnt[r]++; done_q.push_back(r); end
      if (req_ready[r]) rdy_cnt[r]++;
    end
  end

  typedef struct packed {
    logic [7:0]   req;
    logic [15:0]  len;
    logic [127:0] words;
    logic [7:0]   gap;
    logic [31:0]  exp;
  } vec_t;

  vec_t vecs [6];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic start_job(input int r, input int len);
    req_start[r] = 1'b1;
    req_len[r*LEN_W +: LEN_W] = len[15:0];
    @(negedge aclk);
    req_start[r] = 1'b0;
  endtask

  task automatic wait_done(input int r);
    int n;
    n = 0;
    while (!req_done[r] && n < 200) begin @(negedge aclk); n++; end
    chk("done_seen", 32'(req_done[r]), 32'd1);
  endtask

  task automatic run_vec(input int i);
    int r, o, n, t0, b_wr, b_rst, b_dn, b_dno, b_rdy, len;
    r = int'(vecs[i].req);
    o = 1 - r;
    len = int'(vecs[i].len);
    b_wr = wr_cnt; b_rst = rst_cnt; b_dn = done_cnt[r]; b_dno = done_cnt[o]; b_rdy = rdy_cnt[o];
    t0 = cyc;
    start_job(r, len);
    for (int k = 0; k < len; k++) begin
      req_data[r*32 +: 32] = vecs[i].words[k*32 +: 32];
      req_valid[r] = 1'b1;
      n = 0;
      while (!req_ready[r] && n < 50) begin @(negedge aclk); n++; end
      chk("ready_wait", 32'(req_ready[r]), 32'd1);
      @(negedge aclk);
      req_valid[r] = 1'b0;
      if (k == 0) begin
        chk("clr_once_before_wr", rst_cnt - b_rst, 1);
        chk("clr_before_wr", (rst_cyc < last_wr) ? 1 : 0, 1);
      end
      repeat (int'(vecs[i].gap)) @(negedge aclk);
    end
    wait_done(r);
    if (len == 0) chk("len0_latency", cyc - t0, 4);
    @(negedge aclk);
    chk("result", req_result[r*32 +: 32], vecs[i].exp);
    repeat (3) @(negedge aclk);
    chk("pc_writes", wr_cnt - b_wr, len);
    chk("clr_pulses", rst_cnt - b_rst, 1);
    chk("done_pulses", done_cnt[r] - b_dn, 1);
    chk("other_done", done_cnt[o] - b_dno, 0);
    chk("other_ready", rdy_cnt[o] - b_rdy, 0);
  endtask

  task automatic dual(input int first);
    int b, bw, n;
    logic [NREQ-1:0] drop;
    b = done_q.size();
    bw = wr_cnt;
    req_data = {32'h3, 32'h1};
    req_len = {16'd1, 16'd1};
    req_start = 2'b11;
    @(negedge aclk);
    req_start = 2'b00;
    req_valid = 2'b11;
    drop = '0;
    n = 0;
    while (done_q.size() < b + 2 && n < 200) begin
      req_valid = req_valid & ~drop;
      drop = req_valid & req_ready;
      @(negedge aclk);
      n++;
    end
    req_valid = '0;
    chk("dual_both_done", done_q.size() - b, 2);
    if (done_q.size() >= b + 2) begin
      chk("dual_first", done_q[b], first);
      chk("dual_second", done_q[b+1], 1 - first);
    end
    @(negedge aclk);
    chk("dual_result0", req_result[31:0], 32'd1);
    chk("dual_result1", req_result[63:32], 32'd2);
    chk("dual_writes", wr_cnt - bw, 2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_wr, b_rst, b_dn0, b_dn1, n;
    vecs[0] = '{req: 8'd0, len: 16'd2, words: {32'h0, 32'h0, 32'h0000000F, 32'hFFFFFFFF}, gap: 8'd0, exp: 32'd36};
    vecs[1] = '{req: 8'd1, len: 16'd0, words: 128'h0, gap: 8'd0, exp: 32'd0};
    vecs[2] = '{req: 8'd0, len: 16'd3, words: {32'h0, 32'h00FF00FF, 32'h80000000, 32'h00000001}, gap: 8'd2, exp: 32'd18};
    vecs[3] = '{req: 8'd1, len: 16'd1, words: {32'h0, 32'h0, 32'h0, 32'hF0F0F0F0}, gap: 8'd0, exp: 32'd16};
    vecs[4] = '{req: 8'd1, len: 16'd4, words: {4{32'hFFFFFFFF}}, gap: 8'd1, exp: 32'd128};
    vecs[5] = '{req: 8'd0, len: 16'd1, words: {32'h0, 32'h0, 32'h0, 32'h000000FF}, gap: 8'd0, exp: 32'd8};

    repeat (3) @(negedge aclk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_done", 32'(req_done), 0);
    chk("rst_result0", req_result[31:0], 0);
    chk("rst_result1", req_result[63:32], 0);
    chk("rst_pc_wvalid", 32'(pc_wvalid), 0);
    chk("rst_pc_wdata", pc_wdata, 0);
    chk("rst_pc_rst", 32'(pc_rst), 0);
    chk("rst_err", 32'(req_err), 0);
    areset = 1'b0;
    @(negedge aclk);

    for (int i = 0; i < 5; i++) run_vec(i);

    dual(0);
    run_vec(5);
    dual(1);

    // Reset in the middle of a streamed job with another job pending.
    start_job(0, 3);
    req_data[31:0] = 32'hAAAA_AAAA;
    req_valid[0] = 1'b1;
    n = 0;
    while (!req_ready[0] && n < 50) begin @(negedge aclk); n++; end
    @(negedge aclk);
    start_job(1, 1);
    areset = 1'b1;
    @(negedge aclk);
    chk("mid_rst_ready", 32'(req_ready), 0);
    chk("mid_rst_done", 32'(req_done), 0);
    chk("mid_rst_result0", req_result[31:0], 0);
    chk("mid_rst_result1", req_result[63:32], 0);
    chk("mid_rst_pc_wvalid", 32'(pc_wvalid), 0);
    chk("mid_rst_pc_rst", 32'(pc_rst), 0);
    b_wr = wr_cnt; b_rst = rst_cnt; b_dn0 = done_cnt[0]; b_dn1 = done_cnt[1];
    areset = 1'b0;
    req_valid = '0;
    repeat (20) @(negedge aclk);
    chk("post_rst_done0", done_cnt[0] - b_dn0, 0);
    chk("post_rst_done1", done_cnt[1] - b_dn1, 0);
    chk("post_rst_writes", wr_cnt - b_wr, 0);
    chk("post_rst_clr", rst_cnt - b_rst, 0);
    run_vec(3);

`ifdef POPCOUNT_SCHED_TIMEOUT_EN
    force_busy = 1'b1;
    start_job(0, 1);
    req_data[31:0] = 32'h7;
    req_valid[0] = 1'b1;
    n = 0;
    while (!req_ready[0] && n < 50) begin @(negedge aclk); n++; end
    @(negedge aclk);
    req_valid[0] = 1'b0;
    wait_done(0);
    chk("tmo_drain_cycles", cyc - last_wr, 8);
    @(negedge aclk);
    chk("tmo_err0", 32'(req_err[0]), 1);
    chk("tmo_err1", 32'(req_err[1]), 0);
    chk("tmo_result", req_result[31:0], 32'd3);
    force_busy = 1'b0;
    start_job(0, 0);
    chk("tmo_err_cleared", 32'(req_err[0]), 0);
    wait_done(0);
    @(negedge aclk);
`endif

    chk("final_err", 32'(req_err), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
